// File: rtl/vga_pkg.sv
// vga_pkg: shared timing/colour types and defaults for the VGA tile
// scan-out engine.
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_H = '{
    active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48
  };
  localparam vga_timing_t VGA_640x480_V = '{
    active: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33
  };

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Tile word layout: {spare[15:12], R, G, B}
  localparam int TW_X_MSB = 15;
  localparam int TW_X_LSB = 12;
  localparam int TW_R_LSB = 8;
  localparam int TW_G_LSB = 4;
  localparam int TW_B_LSB = 0;

  function automatic rgb444_t tile_rgb(input logic [11:0] c);
    rgb444_t o;
    o.r = c[TW_R_LSB +: 4];
    o.g = c[TW_G_LSB +: 4];
    o.b = c[TW_B_LSB +: 4];
    return o;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register with synchronous clear,
// used to align sync/blank flags with the memory read latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: parametrised VGA raster + tile-mapped scan-out.
// Define VGA_FRAME_STATUS_EN to add frame_start/frame_count ports.
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = int'(VGA_640x480_H.active),
  parameter int          H_FP        = int'(VGA_640x480_H.fp),
  parameter int          H_SYNC      = int'(VGA_640x480_H.sync),
  parameter int          H_BP        = int'(VGA_640x480_H.bp),
  parameter int          V_ACTIVE    = int'(VGA_640x480_V.active),
  parameter int          V_FP        = int'(VGA_640x480_V.fp),
  parameter int          V_SYNC      = int'(VGA_640x480_V.sync),
  parameter int          V_BP        = int'(VGA_640x480_V.bp),
  parameter int          TILE_W      = 16,
  parameter int          TILE_H      = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          MEM_LATENCY = 2,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_q,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        active
`ifdef VGA_FRAME_STATUS_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE / TILE_W;
  localparam int ROWS    = V_ACTIVE / TILE_H;

  if ((COLS * TILE_W != H_ACTIVE) || (ROWS * TILE_H != V_ACTIVE))
  begin : g_bad_tile
    $error("vga_tile_scanout: active area not a whole number of tiles");
  end
  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 4)) begin : g_bad_lat
    $error("vga_tile_scanout: MEM_LATENCY must be 1..4");
  end

  localparam logic [15:0] HA     = 16'(H_ACTIVE);
  localparam logic [15:0] VA     = 16'(V_ACTIVE);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] HA_END = 16'(H_ACTIVE - 1);
  localparam logic [15:0] VA_END = 16'(V_ACTIVE - 1);
  localparam logic [15:0] TX_END = 16'(TILE_W - 1);
  localparam logic [15:0] TY_END = 16'(TILE_H - 1);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] COLS16 = 16'(COLS);

  logic        w_clr;
  logic [15:0] r_h, r_v, r_tx, r_col, r_ty, r_line_base, r_addr;
  logic [15:0] w_h_nx, w_v_nx, w_tx_nx, w_col_nx, w_ty_nx;
  logic [15:0] w_lb_nx, w_addr_nx;

  assign w_clr = reset | ~enable;

  always_comb begin
    w_h_nx   = r_h + 16'd1;
    w_v_nx   = r_v;
    w_tx_nx  = r_tx;
    w_col_nx = r_col;
    w_ty_nx  = r_ty;
    w_lb_nx  = r_line_base;
    if (r_h == H_LAST) begin
      w_h_nx = '0;
      w_v_nx = (r_v == V_LAST) ? 16'd0 : r_v + 16'd1;
    end
    if (r_h == HA_END) begin
      w_tx_nx  = '0;
      w_col_nx = '0;
    end else if (r_h < HA) begin
      if (r_tx == TX_END) begin
        w_tx_nx  = '0;
        w_col_nx = r_col + 16'd1;
      end else begin
        w_tx_nx = r_tx + 16'd1;
      end
    end
    if ((r_h == H_LAST) && (r_v < VA)) begin
      if (r_v == VA_END) begin
        w_ty_nx = '0;
        w_lb_nx = BASE_ADDR;
      end else if (r_ty == TY_END) begin
        w_ty_nx = '0;
        w_lb_nx = r_line_base + COLS16;
      end else begin
        w_ty_nx = r_ty + 16'd1;
      end
    end
    w_addr_nx = (w_v_nx < VA) ? w_lb_nx + w_col_nx : BASE_ADDR;
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_h         <= '0;
      r_v         <= '0;
      r_tx        <= '0;
      r_col       <= '0;
      r_ty        <= '0;
      r_line_base <= BASE_ADDR;
      r_addr      <= BASE_ADDR;
    end else begin
      r_h         <= w_h_nx;
      r_v         <= w_v_nx;
      r_tx        <= w_tx_nx;
      r_col       <= w_col_nx;
      r_ty        <= w_ty_nx;
      r_line_base <= w_lb_nx;
      r_addr      <= w_addr_nx;
    end
  end

  assign mem_addr = r_addr;

  logic w_in_act, w_in_hs, w_in_vs, w_fs;
  assign w_in_act = (r_h < HA) && (r_v < VA);
  assign w_in_hs  = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_in_vs  = (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_fs     = (r_h == 16'd0) && (r_v == VA);

`ifdef VGA_FRAME_STATUS_EN
  localparam int DW = 4;
  logic [DW-1:0] w_dly_in;
  assign w_dly_in = {w_fs, w_in_hs, w_in_vs, w_in_act};
`else
  localparam int DW = 3;
  logic [DW-1:0] w_dly_in;
  logic          w_unused_fs;
  assign w_dly_in    = {w_in_hs, w_in_vs, w_in_act};
  assign w_unused_fs = w_fs;
`endif

  // Last stage of the pin delay is the output register below.
  logic [DW-1:0] w_dly;
  vga_delay_line #(
    .WIDTH (DW),
    .DEPTH (MEM_LATENCY)
  ) u_dly (
    .i_clk (clock),
    .i_clr (w_clr),
    .i_d   (w_dly_in),
    .o_q   (w_dly)
  );

  logic    r_hs, r_vs, r_act;
  rgb444_t r_rgb;
  logic [TW_X_MSB-TW_X_LSB:0] w_unused_q;
  assign w_unused_q = mem_q[TW_X_MSB:TW_X_LSB];

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_act <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_dly[2] ? HS_POL : ~HS_POL;
      r_vs  <= w_dly[1] ? VS_POL : ~VS_POL;
      r_act <= w_dly[0];
      r_rgb <= w_dly[0] ? tile_rgb(mem_q[11:0]) : '0;
    end
  end

  assign hs     = r_hs;
  assign vs     = r_vs;
  assign active = r_act;
  assign vga_r  = r_rgb.r;
  assign vga_g  = r_rgb.g;
  assign vga_b  = r_rgb.b;

`ifdef VGA_FRAME_STATUS_EN
  logic        r_fs;
  logic [15:0] r_fc;

  always_ff @(posedge clock) begin
    if (w_clr) r_fs <= 1'b0;
    else       r_fs <= w_dly[3];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fc <= '0;
    end else if (!w_clr && w_dly[3]) begin
      r_fc <= r_fc + 16'd1;
    end
  end

  assign frame_start = r_fs;
  assign frame_count = r_fc;
`endif

endmodule

// File: tb/tb_vga_tile_scanout.sv
// tb_vga_tile_scanout: random reset/enable drops on a small raster,
// pins and mem_addr checked against a position-based reference model.
module tb_vga_tile_scanout;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int TW = 8, TH = 4;
  localparam int COLS = HA / TW;
  localparam logic [15:0] BASE = 16'h2000;
  localparam int ML = 2;
  localparam int L = ML + 1;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam int NCYC = 12000;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [15:0] mem_addr, mem_q;
  logic        hs, vs, active;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_STATUS_EN
  logic        frame_start;
  logic [15:0] frame_count;
`endif

  always #5 clock = ~clock;

  vga_tile_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .TILE_W (TW), .TILE_H (TH), .BASE_ADDR (BASE),
    .MEM_LATENCY (ML), .HS_POL (HSP), .VS_POL (VSP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .mem_addr (mem_addr),
    .mem_q    (mem_q),
    .hs       (hs),
    .vs       (vs),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b),
    .active   (active)
`ifdef VGA_FRAME_STATUS_EN
    ,
    .frame_start (frame_start),
    .frame_count (frame_count)
`endif
  );

  logic [15:0] mem [0:65535];
  logic [15:0] a_pipe [ML];

  always @(posedge clock) begin
    a_pipe[0] <= mem_addr;
    for (int i = 1; i < ML; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign mem_q = mem[a_pipe[ML-1]];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(int h, int v);
    int a;
    if (v >= VA) return BASE;
    a = int'(BASE) + (v / TH) * COLS + ((h < HA) ? h / TW : 0);
    return 16'(a);
  endfunction

  function automatic logic [14:0] pins_of(int h, int v, bit ok);
    logic a, hx, vx;
    logic [11:0] c;
    if (!ok) return {~HSP, ~VSP, 1'b0, 12'h000};
    a  = (h < HA) && (v < VA);
    hx = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
    vx = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
    c  = a ? mem[addr_of(h, v)][11:0] : 12'h000;
    return {hx, vx, a, c};
  endfunction

  int  ph [NCYC];
  int  pv [NCYC];
  bit  pclr [NCYC];

  initial begin
    int  mh, mv, rst_hold, en_hold, r;
    bit  clr, rst_now, ok;
    logic [14:0] exp_pins;
`ifdef VGA_FRAME_STATUS_EN
    logic        fs_exp;
    logic [15:0] fc_exp;
    fc_exp = '0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mh = 0;
    mv = 0;
    rst_hold = 1;
    en_hold = 0;
    reset = 1'b1;
    enable = 1'b1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clock);
      rst_now = reset;
      clr = reset || !enable;
      if (clr) begin
        mh = 0;
        mv = 0;
      end else begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end
      end
      ph[cyc] = mh;
      pv[cyc] = mv;
      pclr[cyc] = clr;
      @(negedge clock);
      chk("mem_addr", 32'(mem_addr), 32'(addr_of(mh, mv)));
      ok = (cyc >= L);
      for (int k = 0; k < L; k++)
        if (cyc - k >= 0 && pclr[cyc-k]) ok = 1'b0;
      exp_pins = ok ? pins_of(ph[cyc-L], pv[cyc-L], 1'b1)
                    : pins_of(0, 0, 1'b0);
      chk("pins", 32'({hs, vs, active, vga_r, vga_g, vga_b}),
          32'(exp_pins));
`ifdef VGA_FRAME_STATUS_EN
      fs_exp = ok && ph[cyc-L] == 0 && pv[cyc-L] == VA;
      if (rst_now) fc_exp = '0;
      else if (fs_exp) fc_exp = fc_exp + 16'd1;
      chk("frame_start", 32'(frame_start), 32'(fs_exp));
      chk("frame_count", 32'(frame_count), 32'(fc_exp));
`else
      if (rst_now) r = 0;
`endif
      if (cyc == 5000) rst_hold = 1;
      if (cyc == 8000) en_hold = 12;
      if (rst_hold == 0 && en_hold == 0) begin
        r = int'($urandom_range(0, 3999));
        if (r == 0) rst_hold = int'($urandom_range(1, 3));
        else if (r == 1) en_hold = int'($urandom_range(1, 20));
      end
      reset = (rst_hold > 0);
      enable = (en_hold == 0);
      if (rst_hold > 0) rst_hold--;
      if (en_hold > 0) en_hold--;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
